// File: rtl/ir_blob_decoder.sv
// IR camera extended-report parser: extracts one blob's x/y/size, with stall timeout.
// Optional IR_BLOB_AVG_EN: two-sample x/y averaging of consecutive valid decodes.
module ir_blob_decoder #(
   parameter int BLOB_SEL       = 0,
   parameter int HEADER_BYTES   = 1,
   parameter int TIMEOUT_CYCLES = 2500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   input  logic       frame_start,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic [3:0] size,
   output logic       xy_valid,
   output logic       blob_found
);

   localparam int BASE = HEADER_BYTES + 3 * BLOB_SEL;
   localparam int IW   = (BASE < 2) ? 1 : $clog2(BASE + 1);
   localparam int CW   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] LAST_SKIP = IW'(BASE - 1);
   localparam logic [CW-1:0] TMAX      = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [9:0]    NO_BLOB   = 10'h3FF;

   typedef enum logic [2:0] {IDLE, SKIP, BY0, BY1, BY2, DONE} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0]    b0_q, b0_d, b1_q, b1_d;
   logic [9:0]    x_q, x_d, y_q, y_d;
   logic [3:0]    size_q, size_d;
   logic          xv_q, xv_d, bf_q, bf_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          decode;
   logic [9:0]    raw_x, raw_y;
`ifdef IR_BLOB_AVG_EN
   logic [9:0]    xp_q, xp_d, yp_q, yp_d;
   logic          hist_q, hist_d;
   logic [10:0]   sum_x, sum_y;
`endif

   assign raw_x = {byte_in[5:4], b0_q};
   assign raw_y = {byte_in[7:6], b1_q};

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      b0_d    = b0_q;
      b1_d    = b1_q;
      x_d     = x_q;
      y_d     = y_q;
      size_d  = size_q;
      bf_d    = bf_q;
      xv_d    = 1'b0;
      decode  = 1'b0;
      cnt_d   = (cnt_q < TMAX) ? cnt_q + 1'b1 : cnt_q;
`ifdef IR_BLOB_AVG_EN
      xp_d    = xp_q;
      yp_d    = yp_q;
      hist_d  = hist_q;
      sum_x   = {1'b0, xp_q} + {1'b0, raw_x};
      sum_y   = {1'b0, yp_q} + {1'b0, raw_y};
`endif

      if (byte_valid) begin
         if (frame_start) begin
            // frame_start byte is index 0; with BASE==0 it is already b0
            idx_d = IW'(1);
            if (BASE == 0) begin
               b0_d    = byte_in;
               state_d = BY1;
            end else if (BASE == 1) begin
               state_d = BY0;
            end else begin
               state_d = SKIP;
            end
         end else begin
            case (state_q)
               SKIP: begin
                  idx_d = idx_q + 1'b1;
                  if (idx_q == LAST_SKIP) state_d = BY0;
               end
               BY0: begin
                  b0_d    = byte_in;
                  state_d = BY1;
               end
               BY1: begin
                  b1_d    = byte_in;
                  state_d = BY2;
               end
               BY2: begin
                  decode  = 1'b1;
                  state_d = DONE;
               end
               default: ;
            endcase
         end
      end

      if (decode) begin
         xv_d   = 1'b1;
         cnt_d  = '0;
         size_d = byte_in[3:0];
         bf_d   = (raw_y != NO_BLOB);
`ifdef IR_BLOB_AVG_EN
         if (raw_y == NO_BLOB) begin
            x_d    = NO_BLOB;
            y_d    = NO_BLOB;
            hist_d = 1'b0;
         end else begin
            x_d    = hist_q ? sum_x[10:1] : raw_x;
            y_d    = hist_q ? sum_y[10:1] : raw_y;
            xp_d   = raw_x;
            yp_d   = raw_y;
            hist_d = 1'b1;
         end
`else
         x_d = raw_x;
         y_d = raw_y;
`endif
      end else if (cnt_q >= TMAX) begin
         xv_d   = 1'b1;
         cnt_d  = '0;
         x_d    = NO_BLOB;
         y_d    = NO_BLOB;
         size_d = 4'hF;
         bf_d   = 1'b0;
`ifdef IR_BLOB_AVG_EN
         hist_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         x_q     <= NO_BLOB;
         y_q     <= NO_BLOB;
         size_q  <= 4'hF;
         xv_q    <= 1'b0;
         bf_q    <= 1'b0;
         cnt_q   <= '0;
`ifdef IR_BLOB_AVG_EN
         xp_q    <= '0;
         yp_q    <= '0;
         hist_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         x_q     <= x_d;
         y_q     <= y_d;
         size_q  <= size_d;
         xv_q    <= xv_d;
         bf_q    <= bf_d;
         cnt_q   <= cnt_d;
`ifdef IR_BLOB_AVG_EN
         xp_q    <= xp_d;
         yp_q    <= yp_d;
         hist_q  <= hist_d;
`endif
      end
   end

   assign x          = x_q;
   assign y          = y_q;
   assign size       = size_q;
   assign xy_valid   = xv_q;
   assign blob_found = bf_q;

endmodule

// File: tb/tb_ir_blob_decoder.sv
// Directed bench for ir_blob_decoder: three instances share one byte stream
// (blob 0 default timeout, blob 2, blob 0 with a 100-cycle timeout).
module tb_ir_blob_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] byte_in = '0;
   logic       byte_valid = 1'b0;
   logic       frame_start = 1'b0;

   logic [9:0] a_x, a_y, b_x, b_y, t_x, t_y;
   logic [3:0] a_sz, b_sz, t_sz;
   logic       a_xv, a_bf, b_xv, b_bf, t_xv, t_bf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ir_blob_decoder #(.BLOB_SEL(0), .HEADER_BYTES(1)) u_a (
      .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .frame_start(frame_start), .x(a_x), .y(a_y), .size(a_sz),
      .xy_valid(a_xv), .blob_found(a_bf));

   ir_blob_decoder #(.BLOB_SEL(2), .HEADER_BYTES(1)) u_b (
      .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .frame_start(frame_start), .x(b_x), .y(b_y), .size(b_sz),
      .xy_valid(b_xv), .blob_found(b_bf));

   ir_blob_decoder #(.BLOB_SEL(0), .HEADER_BYTES(1), .TIMEOUT_CYCLES(100)) u_t (
      .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .frame_start(frame_start), .x(t_x), .y(t_y), .size(t_sz),
      .xy_valid(t_xv), .blob_found(t_bf));

   // Presents one byte for one clock; returns 1 time unit after the accepting edge.
   task automatic send(input logic [7:0] b, input logic fs);
      byte_in     = b;
      byte_valid  = 1'b1;
      frame_start = fs;
      @(posedge clk);
      #1;
      byte_valid  = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send(8'h00, 1'b1);
      send(b0, 1'b0);
      send(b1, 1'b0);
      send(b2, 1'b0);
   endtask

   task automatic test_reset;
      #2 reset = 1'b1;
      #5;
      checks++; if ({a_x, a_y} !== {10'd1023, 10'd1023}) begin errors++; $display("FAIL reset_xy got %0d/%0d want 1023/1023", a_x, a_y); end
      checks++; if (a_sz !== 4'd15) begin errors++; $display("FAIL reset_size got %0d want 15", a_sz); end
      checks++; if ({a_xv, a_bf, b_xv, b_bf, t_xv, t_bf} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b want 000000", {a_xv, a_bf, b_xv, b_bf, t_xv, t_bf}); end
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_decode;
      send_frame(8'h34, 8'h12, 8'h65);
      checks++; if ({a_x, a_y, a_sz} !== {10'd564, 10'd274, 4'd5}) begin errors++; $display("FAIL decode_xys got %0d/%0d/%0d want 564/274/5", a_x, a_y, a_sz); end
      checks++; if ({a_xv, a_bf} !== 2'b11) begin errors++; $display("FAIL decode_flags got xv=%b bf=%b want 1/1", a_xv, a_bf); end
      checks++; if ({b_xv, b_x} !== {1'b0, 10'd1023}) begin errors++; $display("FAIL decode_sel2_idle got xv=%b x=%0d want 0/1023", b_xv, b_x); end
      @(posedge clk); #1;
      checks++; if ({a_xv, a_x} !== {1'b0, 10'd564}) begin errors++; $display("FAIL decode_hold got xv=%b x=%0d want 0/564", a_xv, a_x); end
   endtask

   task automatic test_no_blob;
      send_frame(8'hFF, 8'hFF, 8'hFF);
      checks++; if ({a_x, a_y, a_sz} !== {10'd1023, 10'd1023, 4'd15}) begin errors++; $display("FAIL noblob_xys got %0d/%0d/%0d want 1023/1023/15", a_x, a_y, a_sz); end
      checks++; if ({a_xv, a_bf} !== 2'b10) begin errors++; $display("FAIL noblob_flags got xv=%b bf=%b want 1/0", a_xv, a_bf); end
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      checks++; if ({a_xv, a_x} !== {1'b0, 10'd1023}) begin errors++; $display("FAIL done_ignores got xv=%b x=%0d want 0/1023", a_xv, a_x); end
   endtask

   task automatic test_blob_sel2;
      int pulses = 0;
      send(8'h00, 1'b1);
      for (int i = 1; i <= 6; i++) begin
         send(8'h20 + 8'(i), 1'b0);
         if (b_xv !== 1'b0 || b_x !== 10'd1023) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL sel2_skip got %0d disturbed cycles want 0", pulses); end
      send(8'h0A, 1'b0);
      send(8'h0B, 1'b0);
      send(8'h50, 1'b0);
      checks++; if ({b_x, b_y, b_sz, b_bf, b_xv} !== {10'd266, 10'd267, 4'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL sel2_decode got %0d/%0d/%0d bf=%b xv=%b want 266/267/0/1/1", b_x, b_y, b_sz, b_bf, b_xv); end
      pulses = 0;
      for (int i = 10; i <= 12; i++) begin
         send(8'h77, 1'b0);
         if (b_xv !== 1'b0 || b_x !== 10'd266) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL sel2_tail got %0d disturbed cycles want 0", pulses); end
   endtask

   task automatic test_resync;
      int pulses = 0;
      send_frame(8'hFF, 8'hFF, 8'hFF);
      send(8'h00, 1'b1); if (a_xv !== 1'b0) pulses++;
      send(8'h34, 1'b0); if (a_xv !== 1'b0) pulses++;
      send(8'h12, 1'b0); if (a_xv !== 1'b0) pulses++;
      send(8'h00, 1'b1); if (a_xv !== 1'b0) pulses++;
      send(8'h34, 1'b0); if (a_xv !== 1'b0) pulses++;
      send(8'h12, 1'b0); if (a_xv !== 1'b0) pulses++;
      checks++; if (pulses != 0) begin errors++; $display("FAIL resync_partial got %0d pulses want 0", pulses); end
      send(8'h65, 1'b0);
      checks++; if ({a_x, a_y, a_sz, a_xv} !== {10'd564, 10'd274, 4'd5, 1'b1}) begin errors++; $display("FAIL resync_decode got %0d/%0d/%0d xv=%b want 564/274/5/1", a_x, a_y, a_sz, a_xv); end
   endtask

   task automatic test_reset_midframe;
      send(8'h00, 1'b1);
      send(8'h34, 1'b0);
      #2 reset = 1'b1;
      #1;
      checks++; if ({a_x, a_y, a_sz, a_bf} !== {10'd1023, 10'd1023, 4'd15, 1'b0}) begin errors++; $display("FAIL midreset_async got %0d/%0d/%0d bf=%b want 1023/1023/15/0", a_x, a_y, a_sz, a_bf); end
      @(posedge clk);
      #1 reset = 1'b0;
      send(8'h12, 1'b0);
      send(8'h65, 1'b0);
      checks++; if ({a_xv, a_x} !== {1'b0, 10'd1023}) begin errors++; $display("FAIL midreset_idle got xv=%b x=%0d want 0/1023", a_xv, a_x); end
   endtask

   task automatic test_timeout;
      int early = 0;
      int late  = 0;
      send_frame(8'h34, 8'h12, 8'h65);
      checks++; if ({t_xv, t_x} !== {1'b1, 10'd564}) begin errors++; $display("FAIL timeout_seed got xv=%b x=%0d want 1/564", t_xv, t_x); end
      for (int i = 1; i < 100; i++) begin
         @(posedge clk); #1;
         if (t_xv !== 1'b0) early++;
      end
      checks++; if (early != 0) begin errors++; $display("FAIL timeout_early got %0d pulses want 0", early); end
      @(posedge clk); #1;
      checks++; if ({t_xv, t_x, t_y, t_sz, t_bf} !== {1'b1, 10'd1023, 10'd1023, 4'd15, 1'b0}) begin errors++; $display("FAIL timeout_fire got xv=%b %0d/%0d/%0d bf=%b want 1 1023/1023/15 0", t_xv, t_x, t_y, t_sz, t_bf); end
      for (int i = 0; i < 99; i++) begin
         @(posedge clk); #1;
         if (t_xv !== 1'b0) late++;
      end
      checks++; if (late != 0) begin errors++; $display("FAIL timeout_repeat got %0d pulses want 0", late); end
   endtask

   task automatic test_average;
      logic [9:0] want2;
`ifdef IR_BLOB_AVG_EN
      want2 = 10'd150;
`else
      want2 = 10'd201;
`endif
      send_frame(8'hFF, 8'hFF, 8'hFF);
      send_frame(8'h64, 8'h10, 8'h00);
      checks++; if ({a_x, a_y} !== {10'd100, 10'd16}) begin errors++; $display("FAIL avg_first got %0d/%0d want 100/16", a_x, a_y); end
      send_frame(8'hC9, 8'h10, 8'h00);
      checks++; if ({a_x, a_y} !== {want2, 10'd16}) begin errors++; $display("FAIL avg_second got %0d/%0d want %0d/16", a_x, a_y, want2); end
      send_frame(8'hFF, 8'hFF, 8'hFF);
      checks++; if ({a_x, a_y, a_bf} !== {10'd1023, 10'd1023, 1'b0}) begin errors++; $display("FAIL avg_clear got %0d/%0d bf=%b want 1023/1023/0", a_x, a_y, a_bf); end
      send_frame(8'h2C, 8'h10, 8'h10);
      checks++; if ({a_x, a_y, a_xv} !== {10'd300, 10'd16, 1'b1}) begin errors++; $display("FAIL avg_after_clear got %0d/%0d xv=%b want 300/16/1", a_x, a_y, a_xv); end
   endtask

   initial begin
      test_reset;
      test_decode;
      test_no_blob;
      test_blob_sel2;
      test_resync;
      test_reset_midframe;
      test_timeout;
      test_average;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ir_blob_decoder.md
Name: ir_blob_decoder

Overview:
- Parses the byte stream read from the IR camera's extended-mode report (over the I2C reader) into one blob's 10-bit x/y position plus size.
- Sits directly upstream of the LED/position consumers, which treat y = 1023 as "no blob found".
- Holds the last decoded position and publishes a one-cycle update strobe.
- Forces the no-blob code when the camera stream stalls.

Parameters:
- BLOB_SEL, 0, which of the 4 blobs in the report is decoded (0..3).
- HEADER_BYTES, 1, leading report bytes discarded before blob 0.
- TIMEOUT_CYCLES, 2500000, clk cycles without a completed decode before outputs are forced to no-blob (must be >= 1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- byte_in  input  8  report byte from the I2C reader.
- byte_valid  input  1  byte_in is valid this cycle; one byte is consumed per asserted cycle.
- frame_start  input  1  qualified by byte_valid; marks byte_in as report byte 0.
- x  output  10  decoded blob x; 1023 = no blob.
- y  output  10  decoded blob y; 1023 = no blob.
- size  output  4  decoded blob size.
- xy_valid  output  1  one-cycle pulse in the cycle new x/y/size first appear.
- blob_found  output  1  high while the held x/y is a real blob (y != 1023).

Behaviour:
- Reset (async, any time, including mid-frame): x=1023, y=1023, size=15, xy_valid=0, blob_found=0, byte index=0, state IDLE, timeout counter=0.
- Byte offset of the selected blob: base = HEADER_BYTES + 3*BLOB_SEL. Its bytes are b0 = base, b1 = base+1, b2 = base+2.
- FSM states:
  - IDLE: wait for byte_valid & frame_start.
  - SKIP: discard bytes until the index reaches base.
  - BY0, BY1, BY2: capture b0, b1, b2.
  - DONE: ignore all bytes until the next frame_start.
- A byte with frame_start is index 0 in every state, including mid-blob. This resynchronises the FSM and discards any partial capture. If base == 0, it goes straight to BY0 handling.
- frame_start without byte_valid is ignored. byte_valid without frame_start in IDLE or DONE is ignored.
- Decode is performed on the b2 capture: x = {b2[5:4], b0}, y = {b2[7:6], b1}, size = b2[3:0].
- Output timing:
  - x, y, size update atomically on the clk edge that accepts b2.
  - xy_valid is high for exactly that following cycle (latency 1 from the b2 byte_valid cycle).
  - blob_found = (decoded y != 1023), registered with x/y.
- An all-0xFF blob decodes to x=1023, y=1023, size=15, blob_found=0. xy_valid still pulses.
- Timeout:
  - The counter clears on every xy_valid and otherwise increments, saturating.
  - When it reaches TIMEOUT_CYCLES: x=y=1023, size=15, blob_found=0, one xy_valid pulse, counter clears.
  - If a b2 decode and the timeout coincide, the decode wins.
- Outputs hold between updates. No backpressure: the upstream byte rate is never throttled.

Optional Feature:
- Macro: IR_BLOB_AVG_EN.
- Defined:
  - A valid (non-1023) decode outputs x = (x_prev + x_new) >> 1 and y likewise, using 11-bit sums truncated to 10 bits.
  - x_prev/y_prev hold the last raw valid sample.
  - A no-blob decode or a timeout bypasses averaging, outputs 1023, and clears history.
  - The first valid sample after a clear is output raw.
  - Latency is unchanged.
- Undefined: raw decode only; no history registers.

Test Plan:
- BLOB_SEL=0, frame bytes 0x00(frame_start), 0x34, 0x12, 0x65 -> one cycle after the 0x65 byte: x=564, y=274, size=5, blob_found=1, xy_valid pulses 1 cycle.
- Frame with blob0 bytes 0xFF,0xFF,0xFF -> x=1023, y=1023, size=15, blob_found=0, xy_valid pulses once.
- BLOB_SEL=2, 13-byte frame with blob2 (bytes 7..9) = 0x0A,0x0B,0x50 -> x=266, y=267, size=0. Bytes 1..6 and 10..12 do not change outputs.
- frame_start asserted mid-blob after 0x34, 0x12 -> partial capture discarded, no xy_valid. The following full blob decodes correctly. Reset asserted mid-frame -> outputs return to 1023/1023/15 immediately.
- TIMEOUT_CYCLES=100, one valid decode, then no bytes -> exactly 100 cycles after xy_valid, x=y=1023, blob_found=0, single xy_valid pulse. No further pulse for the next 99 cycles.
- IR_BLOB_AVG_EN defined: valid samples x=100 then x=201 -> outputs 100 then 150. A following no-blob frame outputs 1023; the next x=300 outputs 300.
